fake_tpi_hs: RTL and testbench

- Parametrised successor to the 28-pin 6523 TPI emulation used on the 1551 paddle.
- Port widths are configurable. The host bus is sampled synchronously to one system clock instead of being clocked by chip select.
- Adds a hardware TCBM DAV/ACK handshake engine with timeout, status/control registers and an interrupt output.
- Sits behind the PLA chip-select decode; the bus side faces the Plus/4 expansion bus, the port side faces the drive-link connector.

---
 rtl/fake_tpi_hs.sv | 242 ++++++++++++++++++++++++
 tb/tb_fake_tpi_hs.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fake_tpi_hs.sv
// fake_tpi_hs: 6523-style triple port interface with a TCBM DAV/ACK
// handshake engine.
//
// The host bus is sampled on the system clock. The first clock with cs_n low
// performs exactly one register access. The handshake engine sends the port A
// byte: DAV falls, the engine waits for ACK low, DAV rises, and the engine
// waits for ACK high. Each wait phase is bounded by a timeout counter.
//
// Ports:
//   clock, _reset             system clock, asynchronous active-low reset
//   cs_n, rs, write_n         chip select (active low), register select, 0 = write
//   data_in / data_out        host write data / registered host read data
//   data_oe                   bus drive enable, !cs_n & write_n (combinational)
//   port_x_in/out/oe          port pins, output values and per-bit output enables
//   irq_n                     registered interrupt, active low
//
// Handshake on port C: bit PC_WIDTH-1 is DAV (output), bit PC_WIDTH-2 is ACK (input).
// The FSM state is visible as the internal signal 'state' for checker binding.
module fake_tpi_hs #(
  parameter int PA_WIDTH    = 8,
  parameter int PB_WIDTH    = 2,
  parameter int PC_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                clock,
  input  logic                _reset,
  input  logic                cs_n,
  input  logic [2:0]          rs,
  input  logic                write_n,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_oe,
  input  logic [PA_WIDTH-1:0] port_a_in,
  output logic [PA_WIDTH-1:0] port_a_out,
  output logic [PA_WIDTH-1:0] port_a_oe,
  input  logic [PB_WIDTH-1:0] port_b_in,
  output logic [PB_WIDTH-1:0] port_b_out,
  output logic [PB_WIDTH-1:0] port_b_oe,
  input  logic [PC_WIDTH-1:0] port_c_in,
  output logic [PC_WIDTH-1:0] port_c_out,
  output logic [PC_WIDTH-1:0] port_c_oe,
  output logic                irq_n
);

  localparam int DAV = PC_WIDTH - 1;
  localparam int ACK = PC_WIDTH - 2;
  localparam logic [TIMEOUT_W-1:0] CNT_ONES = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE
  } state_t;

  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 dav_q;

  // Input synchronisers
  logic [PA_WIDTH-1:0] a_sync [SYNC_STAGES];
  logic [PB_WIDTH-1:0] b_sync [SYNC_STAGES];
  logic [PC_WIDTH-1:0] c_sync [SYNC_STAGES];
  logic [PA_WIDTH-1:0] a_pins;
  logic [PB_WIDTH-1:0] b_pins;
  logic [PC_WIDTH-1:0] c_pins;

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        a_sync[i] <= '0;
        b_sync[i] <= '0;
        c_sync[i] <= '0;
      end
    end else begin
      a_sync[0] <= port_a_in;
      b_sync[0] <= port_b_in;
      c_sync[0] <= port_c_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        a_sync[i] <= a_sync[i-1];
        b_sync[i] <= b_sync[i-1];
        c_sync[i] <= c_sync[i-1];
      end
    end
  end

  assign a_pins = a_sync[SYNC_STAGES-1];
  assign b_pins = b_sync[SYNC_STAGES-1];
  assign c_pins = c_sync[SYNC_STAGES-1];

  // Registers
  logic                cs_q;
  logic [PA_WIDTH-1:0] pra, ddra;
  logic [PB_WIDTH-1:0] prb, ddrb;
  logic [PC_WIDTH-1:0] prc, ddrc;
  logic                hs_en, irq_en;
  logic                done, timeout_f, overrun;

  logic access, wr, rd, pra_wr, sr_rd, busy, start;
  logic ack_s, wait_phase, ack_seen;
  logic set_done, set_timeout, set_overrun;
  logic [7:0] rd_data;

  // cs_q remembers the previous clock's cs_n, so an access is the first
  // clock of a cs_n low period only.
  assign access      = cs_q & ~cs_n;
  assign wr          = access & ~write_n;
  assign rd          = access & write_n;
  assign pra_wr      = wr & (rs == 3'd0);
  assign sr_rd       = rd & (rs == 3'd7);
  assign busy        = (state != S_IDLE);
  assign start       = pra_wr & hs_en & ~busy;
  assign set_overrun = pra_wr & busy;

  assign ack_s       = c_pins[ACK];
  assign wait_phase  = hs_en & ((state == S_STROBE) | (state == S_RELEASE));
  assign ack_seen    = ((state == S_STROBE) & ~ack_s) | ((state == S_RELEASE) & ack_s);
  assign set_done    = hs_en & (state == S_RELEASE) & ack_s;
  // An ACK arriving on the last count wins over the timeout.
  assign set_timeout = wait_phase & ~ack_seen & ((cnt + 1'b1) == CNT_ONES);

  assign data_oe = ~cs_n & write_n;

  always_comb begin
    rd_data = '0;
    case (rs)
      3'd0: rd_data[PA_WIDTH-1:0] = (a_pins & ~ddra) | (pra & ddra);
      3'd1: rd_data[PB_WIDTH-1:0] = (b_pins & ~ddrb) | (prb & ddrb);
      3'd2: rd_data[PC_WIDTH-1:0] = (c_pins & ~ddrc) | (prc & ddrc);
      3'd3: rd_data[PA_WIDTH-1:0] = ddra;
      3'd4: rd_data[PB_WIDTH-1:0] = ddrb;
      3'd5: rd_data[PC_WIDTH-1:0] = ddrc;
      3'd6: rd_data[1:0] = {irq_en, hs_en};
      default: rd_data[3:0] = {overrun, timeout_f, done, busy};
    endcase
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      cs_q      <= 1'b1;
      pra       <= '0;
      prb       <= '0;
      prc       <= '0;
      ddra      <= '0;
      ddrb      <= '0;
      ddrc      <= '0;
      hs_en     <= 1'b0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      timeout_f <= 1'b0;
      overrun   <= 1'b0;
      data_out  <= '0;
      irq_n     <= 1'b1;
    end else begin
      cs_q <= cs_n;
      if (wr) begin
        case (rs)
          3'd0: if (!busy) pra <= data_in[PA_WIDTH-1:0];
          3'd1: prb  <= data_in[PB_WIDTH-1:0];
          3'd2: prc  <= data_in[PC_WIDTH-1:0];
          3'd3: ddra <= data_in[PA_WIDTH-1:0];
          3'd4: ddrb <= data_in[PB_WIDTH-1:0];
          3'd5: ddrc <= data_in[PC_WIDTH-1:0];
          3'd6: begin
            hs_en  <= data_in[0];
            irq_en <= data_in[1];
          end
          default: ;
        endcase
      end
      if (rd) data_out <= rd_data;
      // Sticky flags: an SR read clears them, a coincident set event wins.
      done      <= set_done    | (done & ~sr_rd);
      timeout_f <= set_timeout | (timeout_f & ~sr_rd);
      overrun   <= set_overrun | (overrun & ~sr_rd);
      irq_n     <= ~(irq_en & (done | timeout_f));
    end
  end

  // Handshake FSM. dav_q is the registered DAV level while hs_en is set.
  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      dav_q <= 1'b1;
    end else if (!hs_en) begin
      state <= S_IDLE;
      cnt   <= '0;
      dav_q <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          dav_q <= 1'b1;
          if (start) state <= S_SETUP;
        end
        S_SETUP: begin
          state <= S_STROBE;
          cnt   <= '0;
          dav_q <= 1'b0;
        end
        S_STROBE: begin
          if (!ack_s) begin
            state <= S_RELEASE;
            cnt   <= '0;
            dav_q <= 1'b1;
          end else if (set_timeout) begin
            state <= S_IDLE;
            dav_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          dav_q <= 1'b1;
          if (ack_s || set_timeout) state <= S_IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          dav_q <= 1'b1;
        end
      endcase
    end
  end

  // Port drivers
  assign port_a_out = pra;
  assign port_a_oe  = ddra;
  assign port_b_out = prb;
  assign port_b_oe  = ddrb;

  always_comb begin
    port_c_out = prc;
    port_c_oe  = ddrc;
    if (hs_en) begin
      port_c_out[DAV] = dav_q;
      port_c_oe[DAV]  = 1'b1;
    end
  end

endmodule

// File: tb/tb_fake_tpi_hs.sv
// Testbench for fake_tpi_hs: register access against a register-file model,
// handshake timing derived from the synchroniser depth and the ACK delays,
// timeout, overrun, abort and asynchronous reset.
module tb_fake_tpi_hs;

  localparam int PA_W   = 8;
  localparam int PB_W   = 2;
  localparam int PC_W   = 2;
  localparam int SYNC   = 2;
  localparam int TW     = 8;
  localparam int DAV    = PC_W - 1;
  localparam int ACK    = PC_W - 2;
  localparam int TO_CYC = (1 << TW) - 1;

  logic            clock = 1'b0;
  logic            _reset;
  logic            cs_n;
  logic [2:0]      rs;
  logic            write_n;
  logic [7:0]      data_in;
  logic [7:0]      data_out;
  logic            data_oe;
  logic [PA_W-1:0] port_a_in, port_a_out, port_a_oe;
  logic [PB_W-1:0] port_b_in, port_b_out, port_b_oe;
  logic [PC_W-1:0] port_c_in, port_c_out, port_c_oe;
  logic            irq_n;

  int checks = 0;
  int errors = 0;

  // Reference model of the programmer-visible register file
  logic [7:0] m_pr [3];
  logic [7:0] m_ddr [3];
  logic [7:0] m_pins [3];
  logic [7:0] m_mask [3];
  logic [7:0] m_cr;

  fake_tpi_hs #(
    .PA_WIDTH(PA_W), .PB_WIDTH(PB_W), .PC_WIDTH(PC_W),
    .SYNC_STAGES(SYNC), .TIMEOUT_W(TW)
  ) dut (
    .clock(clock), ._reset(_reset), .cs_n(cs_n), .rs(rs), .write_n(write_n),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .port_a_in(port_a_in), .port_a_out(port_a_out), .port_a_oe(port_a_oe),
    .port_b_in(port_b_in), .port_b_out(port_b_out), .port_b_oe(port_b_oe),
    .port_c_in(port_c_in), .port_c_out(port_c_out), .port_c_oe(port_c_oe),
    .irq_n(irq_n)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: both start and end just after a falling edge, with cs_n high.
  task automatic bus_write(input logic [2:0] r, input logic [7:0] d);
    cs_n = 1'b0; rs = r; write_n = 1'b0; data_in = d;
    @(posedge clock); @(negedge clock);
    cs_n = 1'b1; write_n = 1'b1;
    @(posedge clock); @(negedge clock);
  endtask

  task automatic bus_read(input logic [2:0] r, output logic [7:0] d);
    cs_n = 1'b0; rs = r; write_n = 1'b1;
    @(posedge clock); @(negedge clock);
    d = data_out;
    cs_n = 1'b1;
    @(posedge clock); @(negedge clock);
  endtask

  function automatic logic [7:0] model_read(input int r);
    if (r < 3)      return ((m_pins[r] & ~m_ddr[r]) | (m_pr[r] & m_ddr[r])) & m_mask[r];
    else if (r < 6) return m_ddr[r-3] & m_mask[r-3];
    else if (r == 6) return m_cr;
    else            return 8'h00;
  endfunction

  task automatic test_reset();
    logic [7:0] d;
    checks++;
    if ({port_a_oe, port_b_oe, port_c_oe} !== '0) begin
      errors++; $display("FAIL reset_oe: got %0h expected 0", {port_a_oe, port_b_oe, port_c_oe});
    end
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b expected 1", irq_n); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %0h expected 0", data_out); end
    checks++;
    if (data_oe !== 1'b0) begin errors++; $display("FAIL data_oe_idle: got %b expected 0", data_oe); end
    cs_n = 1'b0; write_n = 1'b1; rs = 3'd7;
    #1;
    checks++;
    if (data_oe !== 1'b1) begin errors++; $display("FAIL data_oe_read: got %b expected 1", data_oe); end
    write_n = 1'b0;
    #1;
    checks++;
    if (data_oe !== 1'b0) begin errors++; $display("FAIL data_oe_write: got %b expected 0", data_oe); end
    write_n = 1'b1; cs_n = 1'b1;
    @(negedge clock);
    for (int r = 0; r < 8; r++) begin
      bus_read(3'(r), d);
      checks++;
      if (d !== 8'h00) begin errors++; $display("FAIL reset_read rs=%0d: got %0h expected 00", r, d); end
    end
  endtask

  task automatic test_port_a();
    logic [7:0] d;
    bus_write(3'd3, 8'hF0); m_ddr[0] = 8'hF0;
    bus_write(3'd0, 8'hA5); m_pr[0] = 8'hA5;
    port_a_in = 8'h3C; m_pins[0] = 8'h3C;
    repeat (SYNC + 1) @(negedge clock);
    bus_read(3'd0, d);
    checks++;
    if (d !== 8'hAC) begin errors++; $display("FAIL pra_mixed_read: got %0h expected ac", d); end
    checks++;
    if (port_a_oe !== 8'hF0) begin errors++; $display("FAIL port_a_oe: got %0h expected f0", port_a_oe); end
    checks++;
    if (port_a_out !== 8'hA5) begin errors++; $display("FAIL port_a_out: got %0h expected a5", port_a_out); end
  endtask

  task automatic test_random_regs();
    logic [7:0] d, exp;
    int r;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        port_a_in = PA_W'($urandom); port_b_in = PB_W'($urandom); port_c_in = PC_W'($urandom);
        m_pins[0] = 8'(port_a_in); m_pins[1] = 8'(port_b_in); m_pins[2] = 8'(port_c_in);
        repeat (SYNC + 1) @(negedge clock);
      end
      r = $urandom_range(0, 7);
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        if (r == 6) d[0] = 1'b0;
        bus_write(3'(r), d);
        if (r < 3)       m_pr[r] = d & m_mask[r];
        else if (r < 6)  m_ddr[r-3] = d & m_mask[r-3];
        else if (r == 6) m_cr = d & 8'h02;
      end else begin
        bus_read(3'(r), d);
        exp = model_read(r);
        checks++;
        if (d !== exp) begin errors++; $display("FAIL rand_read rs=%0d: got %0h expected %0h", r, d, exp); end
      end
      checks++;
      if ({8'(port_a_out), 8'(port_b_out), 8'(port_c_out), 8'(port_a_oe), 8'(port_b_oe), 8'(port_c_oe)}
          !== {m_pr[0], m_pr[1], m_pr[2], m_ddr[0], m_ddr[1], m_ddr[2]}) begin
        errors++;
        $display("FAIL rand_ports: got out %0h/%0h/%0h oe %0h/%0h/%0h expected out %0h/%0h/%0h oe %0h/%0h/%0h",
                 port_a_out, port_b_out, port_c_out, port_a_oe, port_b_oe, port_c_oe,
                 m_pr[0], m_pr[1], m_pr[2], m_ddr[0], m_ddr[1], m_ddr[2]);
      end
    end
    port_c_in[ACK] = 1'b1; m_pins[2][ACK] = 1'b1;
    repeat (SYNC + 1) @(negedge clock);
  endtask

  // One complete transfer. ACK falls d1 cycles after DAV is seen low and
  // rises d2 cycles after DAV is seen high; each edge needs SYNC+1 clocks
  // to travel through the synchroniser into the FSM.
  task automatic do_handshake(input logic [7:0] val, input int d1, input int d2, input bit irq_on);
    logic [7:0] d;
    int n, irq_at;
    bit dav_dropped;
    cs_n = 1'b0; rs = 3'd0; write_n = 1'b0; data_in = val;
    @(posedge clock); @(negedge clock);
    cs_n = 1'b1; write_n = 1'b1;
    m_pr[0] = val;
    checks++;
    if (port_c_out[DAV] !== 1'b1) begin errors++; $display("FAIL setup_dav: got %b expected 1", port_c_out[DAV]); end
    @(posedge clock); @(negedge clock);
    checks++;
    if (port_c_out[DAV] !== 1'b0) begin errors++; $display("FAIL strobe_dav: got %b expected 0", port_c_out[DAV]); end
    checks++;
    if (port_a_out !== val) begin errors++; $display("FAIL hs_data: got %0h expected %0h", port_a_out, val); end
    n = 0;
    while (port_c_out[DAV] === 1'b0 && n < 200) begin
      if (n == d1) port_c_in[ACK] = 1'b0;
      @(posedge clock); @(negedge clock);
      n++;
    end
    checks++;
    if (n != d1 + SYNC + 1) begin errors++; $display("FAIL dav_low_len: got %0d expected %0d", n, d1 + SYNC + 1); end
    irq_at = -1; dav_dropped = 1'b0;
    for (int m = 0; m < d2 + SYNC + 6; m++) begin
      if (m == d2) port_c_in[ACK] = 1'b1;
      if (irq_n === 1'b0 && irq_at < 0) irq_at = m;
      if (port_c_out[DAV] !== 1'b1) dav_dropped = 1'b1;
      @(posedge clock); @(negedge clock);
    end
    checks++;
    if (dav_dropped) begin errors++; $display("FAIL release_dav: got 0 expected 1"); end
    checks++;
    if (irq_at != (irq_on ? d2 + SYNC + 2 : -1)) begin
      errors++; $display("FAIL irq_timing: got %0d expected %0d", irq_at, irq_on ? d2 + SYNC + 2 : -1);
    end
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h02) begin errors++; $display("FAIL sr_done: got %0h expected 02", d); end
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL sr_cleared: got %0h expected 00", d); end
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_cleared: got %b expected 1", irq_n); end
  endtask

  task automatic test_handshake();
    bus_write(3'd6, 8'h03); m_cr = 8'h02;
    do_handshake(8'h55, 5, 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    bit irq_on;
    for (int i = 0; i < 5; i++) begin
      irq_on = 1'($urandom_range(0, 1));
      bus_write(3'd6, {6'b0, irq_on, 1'b1});
      m_cr = {6'b0, irq_on, 1'b0};
      do_handshake(8'($urandom), $urandom_range(0, 6), $urandom_range(0, 6), irq_on);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    int n;
    bus_write(3'd6, 8'h01); m_cr = 8'h00;
    bus_write(3'd0, 8'($urandom));
    n = 0;
    while (port_c_out[DAV] === 1'b0 && n < 1000) begin
      @(posedge clock); @(negedge clock);
      n++;
    end
    checks++;
    if (n != TO_CYC) begin errors++; $display("FAIL strobe_timeout_len: got %0d expected %0d", n, TO_CYC); end
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL timeout_irq_masked: got %b expected 1", irq_n); end
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL sr_timeout: got %0h expected 04", d); end
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL sr_timeout_clr: got %0h expected 00", d); end
    // Timeout while waiting for ACK to return high
    bus_write(3'd6, 8'h03); m_cr = 8'h02;
    bus_write(3'd0, 8'($urandom));
    port_c_in[ACK] = 1'b0;
    n = 0;
    while (port_c_out[DAV] === 1'b0 && n < 50) begin
      @(posedge clock); @(negedge clock);
      n++;
    end
    repeat (100) @(negedge clock);
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL sr_release_busy: got %0h expected 01", d); end
    repeat (300) @(negedge clock);
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL release_timeout_irq: got %b expected 0", irq_n); end
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h04) begin errors++; $display("FAIL sr_release_timeout: got %0h expected 04", d); end
    port_c_in[ACK] = 1'b1;
    repeat (SYNC + 1) @(negedge clock);
  endtask

  task automatic test_overrun_abort();
    logic [7:0] d, v1;
    bus_write(3'd5, 8'h00); m_ddr[2] = 8'h00;
    bus_write(3'd2, 8'h02); m_pr[2] = 8'h02;
    bus_write(3'd6, 8'h01); m_cr = 8'h00;
    v1 = 8'h80 | 8'($urandom_range(0, 127));
    bus_write(3'd0, v1); m_pr[0] = v1;
    checks++;
    if (port_c_out !== 2'b00 || port_c_oe !== 2'b10) begin
      errors++; $display("FAIL forced_dav: got out %b oe %b expected out 00 oe 10", port_c_out, port_c_oe);
    end
    bus_write(3'd0, 8'h11);
    checks++;
    if (port_a_out !== v1) begin errors++; $display("FAIL overrun_data: got %0h expected %0h", port_a_out, v1); end
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h09) begin errors++; $display("FAIL sr_overrun: got %0h expected 09", d); end
    bus_write(3'd6, 8'h00);
    checks++;
    if (port_c_out !== 2'b10 || port_c_oe !== 2'b00) begin
      errors++; $display("FAIL abort_release: got out %b oe %b expected out 10 oe 00", port_c_out, port_c_oe);
    end
    repeat (300) @(negedge clock);
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL sr_after_abort: got %0h expected 00", d); end
  endtask

  task automatic test_reset_mid_strobe();
    logic [7:0] d;
    int n;
    bus_write(3'd6, 8'h01);
    bus_write(3'd0, 8'($urandom));
    n = 0;
    while (port_c_out[DAV] !== 1'b0 && n < 50) begin
      @(posedge clock); @(negedge clock);
      n++;
    end
    checks++;
    if (port_c_out[DAV] !== 1'b0) begin errors++; $display("FAIL pre_reset_dav: got %b expected 0", port_c_out[DAV]); end
    #2 _reset = 1'b0;
    #1;
    checks++;
    if ({port_a_out, port_a_oe, port_c_out, port_c_oe} !== '0 || irq_n !== 1'b1 || data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got a %0h/%0h c %b/%b irq_n %b data_out %0h expected all 0, irq_n 1",
               port_a_out, port_a_oe, port_c_out, port_c_oe, irq_n, data_out);
    end
    @(negedge clock);
    _reset = 1'b1;
    @(negedge clock);
    bus_read(3'd7, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL sr_after_reset: got %0h expected 00", d); end
    bus_read(3'd6, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL cr_after_reset: got %0h expected 00", d); end
  endtask

  initial begin
    cs_n = 1'b1; rs = '0; write_n = 1'b1; data_in = '0;
    port_a_in = '0; port_b_in = '0; port_c_in = '0;
    _reset = 1'b0;
    m_mask[0] = 8'hFF; m_mask[1] = 8'h03; m_mask[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      m_pr[i] = '0; m_ddr[i] = '0; m_pins[i] = '0;
    end
    m_cr = '0;
    repeat (3) @(negedge clock);
    _reset = 1'b1;
    @(negedge clock);

    test_reset();
    test_port_a();
    test_random_regs();
    test_handshake();
    test_back_to_back();
    test_timeout();
    test_overrun_abort();
    test_reset_mid_strobe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
